// File: rtl/auto_player_pkg.sv
// Shared game definitions: player FSM states, move width and LFSR taps.
//   MOVE_W    : width of a move / LFSR value
//   COUNT_W   : width of the move counter
//   GAP_W     : width of the settle-gap counter
//   LFSR_TAPS : feedback taps for x^4 + x^3 + 1 (bits 3 and 2)
package auto_player_pkg;

    localparam int unsigned MOVE_W  = 4;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned GAP_W   = 8;

    localparam logic [MOVE_W-1:0] LFSR_TAPS = 4'b1100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEWG  = 3'd1,
        LOAD  = 3'd2,
        DRIVE = 3'd3,
        WAIT  = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Fibonacci step: shift left, feed back the XOR of the tapped bits.
    function automatic logic [MOVE_W-1:0] lfsr_next(input logic [MOVE_W-1:0] v);
        return {v[MOVE_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/auto_player_lfsr4.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1), period 15, never reaches zero.
//   clock   : rising-edge clock
//   reset_L : async active-low reset, loads seed (zero seed becomes 4'b0001)
//   seed    : reset value, expected to be a constant
//   advance : step the sequence once this cycle
//   value   : current LFSR contents
module auto_player_lfsr4
    import auto_player_pkg::*;
(
    input  logic              clock,
    input  logic              reset_L,
    input  logic [MOVE_W-1:0] seed,
    input  logic              advance,
    output logic [MOVE_W-1:0] value
);

    logic [MOVE_W-1:0] seed_safe;

    // An all-zero state would lock up the sequence.
    assign seed_safe = (seed == '0) ? MOVE_W'(1) : seed;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            value <= seed_safe;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/auto_player.sv
// Automated player: drives hMove/enter/newGame into the game and watches win.
//   clock, reset_L : rising-edge clock, async active-low reset
//   start          : level, begins a new game when sampled in IDLE or DONE
//   win            : game's win flag, sampled only in CHECK
//   hMove          : move presented to the game, stable a cycle before enter
//   enter, newGame : one-cycle submit / game-clear pulses
//   busy, done     : activity status; lost qualifies done (1 = budget exhausted)
//   moveCount      : moves submitted in the current game
module auto_player
    import auto_player_pkg::*;
#(
    parameter logic [MOVE_W-1:0] SEED      = 4'b1001,
    parameter int unsigned       GAP       = 4,
    parameter int unsigned       MAX_MOVES = 12
)(
    input  logic               clock,
    input  logic               reset_L,
    input  logic               start,
    input  logic               win,
    output logic [MOVE_W-1:0]  hMove,
    output logic               enter,
    output logic               newGame,
    output logic               busy,
    output logic               done,
    output logic               lost,
    output logic [COUNT_W-1:0] moveCount
);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [MOVE_W-1:0]  hmove_d;
    logic [COUNT_W-1:0] count_d;
    logic               lost_d;
    logic               advance;
    logic [MOVE_W-1:0]  lfsr_value;

    auto_player_lfsr4 u_lfsr (
        .clock   (clock),
        .reset_L (reset_L),
        .seed    (SEED),
        .advance (advance),
        .value   (lfsr_value)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        hmove_d = hMove;
        count_d = moveCount;
        lost_d  = lost;
        advance = 1'b0;

        unique case (state_q)
            IDLE:  if (start) state_d = NEWG;
            NEWG:  state_d = LOAD;
            LOAD:  state_d = DRIVE;
            DRIVE: begin
                state_d = WAIT;
                advance = 1'b1;
                count_d = moveCount + COUNT_W'(1);
                gap_d   = GAP_W'(GAP - 1);
            end
            WAIT: begin
                if (gap_q == '0) state_d = CHECK;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            CHECK: begin
                // Win is tested first so a win on the last budgeted move counts.
                if (win) begin
                    state_d = DONE;
                    lost_d  = 1'b0;
                end else if (moveCount == COUNT_W'(MAX_MOVES)) begin
                    state_d = DONE;
                    lost_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE:    if (start) state_d = NEWG;
            default: state_d = IDLE;
        endcase

        if (state_d == NEWG) begin
            count_d = '0;
            lost_d  = 1'b0;
        end
        // Present the move on entering LOAD so it leads enter by a full cycle.
        if (state_d == LOAD) hmove_d = lfsr_value;
    end

    // State and output registers; pulses are decoded from the next state.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            hMove     <= '0;
            enter     <= 1'b0;
            newGame   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lost      <= 1'b0;
            moveCount <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            hMove     <= hmove_d;
            enter     <= (state_d == DRIVE);
            newGame   <= (state_d == NEWG);
            busy      <= (state_d != IDLE) && (state_d != DONE);
            done      <= (state_d == DONE);
            lost      <= lost_d;
            moveCount <= count_d;
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: event-level model for u0 plus directed literal checks,
// and a second instance (SEED=0, GAP=1) for the zero-seed and short-gap cases.
module tb_auto_player;
    import auto_player_pkg::*;

    localparam logic [3:0]  SEED0 = 4'b1001;
    localparam int unsigned GAP0  = 4;
    localparam int unsigned MAX0  = 12;
    localparam int unsigned GAP1  = 1;
    localparam int unsigned MAX1  = 15;

    logic clock   = 1'b0;
    logic reset_L = 1'b0;

    logic       start0, win0, enter0, ng0, busy0, done0, lost0;
    logic [3:0] hmove0;
    logic [7:0] count0;
    logic       start1, win1, enter1, ng1, busy1, done1, lost1;
    logic [3:0] hmove1;
    logic [7:0] count1;

    always #5 clock = ~clock;

    auto_player #(.SEED(SEED0), .GAP(GAP0), .MAX_MOVES(MAX0)) u0 (
        .clock(clock), .reset_L(reset_L), .start(start0), .win(win0),
        .hMove(hmove0), .enter(enter0), .newGame(ng0), .busy(busy0),
        .done(done0), .lost(lost0), .moveCount(count0)
    );

    auto_player #(.SEED(4'b0000), .GAP(GAP1), .MAX_MOVES(MAX1)) u1 (
        .clock(clock), .reset_L(reset_L), .start(start1), .win(win1),
        .hMove(hmove1), .enter(enter1), .newGame(ng1), .busy(busy1),
        .done(done1), .lost(lost1), .moveCount(count1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // x^4 + x^3 + 1 step in plain integer arithmetic.
    function automatic int m_next(input int v);
        return ((v << 1) & 15) | (((v >> 3) ^ (v >> 2)) & 1);
    endfunction

    // ---------------- event-level model of u0 ----------------
    int cyc = 0;
    int m_lfsr, m_cnt, m_last_move, m_prev_hmove;
    bit m_free, m_done, m_lost;
    int exp_ng, exp_enter, check_at, exp_done_at;
    int n_enter = 0;
    int n_ng    = 0;
    int enter_cyc[$];
    int enter_mv[$];

    always @(negedge clock) begin
        cyc++;
        if (!reset_L) begin
            m_lfsr      = (SEED0 == 4'd0) ? 1 : int'(SEED0);
            m_free      = 1'b1;
            m_done      = 1'b0;
            m_lost      = 1'b0;
            m_cnt       = 0;
            m_last_move = 0;
            exp_ng      = -1;
            exp_enter   = -1;
            check_at    = -1;
            exp_done_at = -1;
            chk("rst_enter",   int'(enter0), 0);
            chk("rst_newgame", int'(ng0),    0);
            chk("rst_busy",    int'(busy0),  0);
            chk("rst_count",   int'(count0), 0);
        end else begin
            chk("newgame", int'(ng0), int'(cyc == exp_ng));
            if (cyc == exp_ng) begin
                m_free    = 1'b0;
                m_done    = 1'b0;
                m_lost    = 1'b0;
                m_cnt     = 0;
                exp_enter = cyc + 2;
                n_ng++;
                chk("ng_count", int'(count0), 0);
                chk("ng_lost",  int'(lost0),  0);
            end
            chk("enter", int'(enter0), int'(cyc == exp_enter));
            if (cyc == exp_enter) begin
                chk("enter_hmove", int'(hmove0), m_lfsr);
                chk("hmove_setup", m_prev_hmove, m_lfsr);
                chk("enter_count", int'(count0), m_cnt);
                enter_cyc.push_back(cyc);
                enter_mv.push_back(int'(hmove0));
                n_enter++;
                m_last_move = m_lfsr;
                m_lfsr      = m_next(m_lfsr);
                m_cnt++;
                check_at    = cyc + int'(GAP0) + 1;
                exp_enter   = -1;
            end
            if (cyc == check_at) begin
                if (win0) begin
                    exp_done_at = cyc + 1;
                    m_lost      = 1'b0;
                end else if (m_cnt == int'(MAX0)) begin
                    exp_done_at = cyc + 1;
                    m_lost      = 1'b1;
                end else begin
                    exp_enter = cyc + 2;
                end
                check_at = -1;
            end
            if (cyc == exp_done_at) begin
                m_done      = 1'b1;
                m_free      = 1'b1;
                exp_done_at = -1;
            end
            chk("busy", int'(busy0), int'(!m_free));
            chk("done", int'(done0), int'(m_done));
            if (m_done) begin
                chk("done_lost",  int'(lost0),  int'(m_lost));
                chk("done_count", int'(count0), m_cnt);
                chk("done_hmove", int'(hmove0), m_last_move);
            end
            if (m_free && start0 && exp_ng <= cyc) exp_ng = cyc + 1;
        end
        m_prev_hmove = int'(hmove0);
    end

    // ---------------- u1 event capture ----------------
    int cyc1   = 0;
    int ng1_cyc = -1;
    int e1_cyc[$];
    int e1_mv[$];

    always @(negedge clock) begin
        cyc1++;
        if (reset_L) begin
            if (ng1 && ng1_cyc < 0) ng1_cyc = cyc1;
            if (enter1) begin
                e1_cyc.push_back(cyc1);
                e1_mv.push_back(int'(hmove1));
            end
        end
    end

    task automatic wait_enters(input int target, input int bound);
        int k = 0;
        while (n_enter < target && k < bound) begin
            @(negedge clock); #1;
            k++;
        end
        if (n_enter < target) chk("timeout_enter", n_enter, target);
    endtask

    task automatic wait_done0(input int bound);
        int k = 0;
        while (!done0 && k < bound) begin
            @(negedge clock); #1;
            k++;
        end
        if (!done0) chk("timeout_done0", 0, 1);
    endtask

    task automatic pulse_start0();
        @(posedge clock); #1 start0 = 1'b1;
        @(posedge clock); #1 start0 = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        start0 = 1'b0;
        start1 = 1'b0;
        win0   = 1'b0;
        win1   = 1'b0;

        // Reset values.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hmove", int'(hmove0), 0);
        chk("rst_done",  int'(done0),  0);
        chk("rst_lost",  int'(lost0),  0);
        reset_L = 1'b1;

        // Zero seed, GAP=1, no win: 15 moves, none zero, 4 cycles apart.
        @(posedge clock); #1 start1 = 1'b1;
        @(posedge clock); #1 start1 = 1'b0;
        k = 0;
        while (!done1 && k < 200) begin
            @(negedge clock); #1;
            k++;
        end
        chk("u1_done",  int'(done1),  1);
        chk("u1_lost",  int'(lost1),  1);
        chk("u1_count", int'(count1), 15);
        chk("u1_moves", e1_mv.size(), 15);
        if (e1_mv.size() > 0) begin
            chk("u1_first_move", e1_mv[0], 1);
            chk("u1_first_enter", e1_cyc[0] - ng1_cyc, 2);
        end
        for (int i = 0; i < e1_mv.size(); i++) begin
            chk("u1_nonzero", int'(e1_mv[i] != 0), 1);
            if (i > 0) begin
                chk("u1_spacing", e1_cyc[i] - e1_cyc[i-1], int'(GAP1) + 3);
                chk("u1_seq", e1_mv[i], m_next(e1_mv[i-1]));
            end
        end

        // Game 1: win held from the 3rd enter, done after the 3rd check.
        pulse_start0();
        wait_enters(3, 100);
        win0 = 1'b1;
        wait_done0(100);
        chk("g1_lost",   int'(lost0),  0);
        chk("g1_count",  int'(count0), 3);
        chk("g1_hmove",  int'(hmove0), 4'b0110);
        chk("g1_mv0",    enter_mv[0],  4'b1001);
        chk("g1_mv1",    enter_mv[1],  4'b0011);
        chk("g1_mv2",    enter_mv[2],  4'b0110);
        chk("g1_gap",    enter_cyc[1] - enter_cyc[0], 7);
        win0 = 1'b0;

        // Game 2: no win, start toggled during play; budget of 12 exhausted.
        base = n_enter;
        @(posedge clock); #1 start0 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1 start0 = ~start0;
        end
        start0 = 1'b0;
        wait_done0(200);
        chk("g2_newgames", n_ng, 2);
        chk("g2_enters",   n_enter - base, 12);
        chk("g2_lost",     int'(lost0),  1);
        chk("g2_count",    int'(count0), 12);
        chk("g2_hmove",    int'(hmove0), 4'b0100);
        chk("g2_first_mv", enter_mv[3],  4'b1101);
        chk("g2_gap",      enter_cyc[5] - enter_cyc[4], 7);

        // Game 3: async reset while enter is high.
        base = n_enter;
        pulse_start0();
        wait_enters(base + 2, 100);
        chk("g3_enter_pre", int'(enter0), 1);
        chk("g3_count_pre", int'(count0), 1);
        reset_L = 1'b0;
        #1;
        chk("async_enter", int'(enter0), 0);
        chk("async_busy",  int'(busy0),  0);
        chk("async_count", int'(count0), 0);
        repeat (2) @(posedge clock);
        #1 reset_L = 1'b1;

        // After reset the sequence restarts from the seed.
        base = n_enter;
        pulse_start0();
        wait_enters(base + 1, 100);
        chk("reseed_mv", enter_mv[base], 4'b1001);
        repeat (10) @(posedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
